// File: rtl/usr_shift_controller.sv
// Command sequencer for a universal shift register: expands LOAD/SHR/SHL/ROTL
// commands into per-cycle mode-select and serial/parallel drive, then pulses done.
module usr_shift_controller #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             Clear_b,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] sr_q,
  output logic [1:0]       sel_line,
  output logic [WIDTH-1:0] par_in,
  output logic             msb_in,
  output logic             lsb_in,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROTL = 2'b11;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] rem;
  logic             fill_q;

  // Only the MSB of the live register value feeds the rotate path.
  logic unused_sr;
  assign unused_sr = ^sr_q[WIDTH-2:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      state  <= S_IDLE;
      op_q   <= OP_LOAD;
      data_q <= '0;
      rem    <= '0;
      fill_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            rem    <= cmd_count;
            fill_q <= cmd_fill;
            if (cmd_op == OP_LOAD)          state <= S_LOAD;
            else if (cmd_count == '0)       state <= S_DONE;
            else                            state <= S_SHIFT;
          end
        end
        S_LOAD:  state <= S_DONE;
        S_SHIFT: begin
          rem <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    cmd_ready = 1'b0;
    sel_line  = SEL_HOLD;
    par_in    = '0;
    msb_in    = 1'b0;
    lsb_in    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_LOAD: begin
        busy     = 1'b1;
        sel_line = SEL_LOAD;
        par_in   = data_q;
      end
      S_SHIFT: begin
        busy = 1'b1;
        case (op_q)
          OP_SHR: begin
            sel_line = SEL_RIGHT;
            msb_in   = fill_q;
          end
          OP_SHL: begin
            sel_line = SEL_LEFT;
            lsb_in   = fill_q;
          end
          OP_ROTL: begin
            // Rotate feedback is taken live from the register, not captured.
            sel_line = SEL_LEFT;
            lsb_in   = sr_q[WIDTH-1];
          end
          default: sel_line = SEL_HOLD;
        endcase
      end
      default: done = 1'b1;
    endcase
  end

endmodule
